// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32I instruction-fetch stage: PC register, instruction-memory
//            address, IF/ID pipeline register, stall/flush/redirect handling.
//            Optional perf counters enabled by macro FETCH_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [31:0]       imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    output logic [31:0]       if_id_pc_o,
    output logic [31:0]       if_id_pc4_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [CNT_W-1:0]  perf_fetch_o,
    output logic [CNT_W-1:0]  perf_bubble_o,
`endif
    output logic              misalign_o
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_misalign;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = {redirect_pc_i[31:2], 2'b00};

    // Redirect beats stall; a redirect always squashes the wrong-path fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'd0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_i) begin
                r_pc          <= w_redirect_target;
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
            end else if (stall_i) begin
                if (flush_i) begin
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_valid <= 1'b0;
                end
            end else begin
                r_pc <= w_pc_plus4;
                if (flush_i) begin
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_valid <= 1'b0;
                end else begin
                    r_if_id_pc    <= r_pc;
                    r_if_id_pc4   <= w_pc_plus4;
                    r_if_id_instr <= imem_instr_i;
                    r_if_id_valid <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_fetch;
    logic [CNT_W-1:0] r_perf_bubble;

    // Stalled cycles count as neither a fetch nor a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else if (redirect_i) begin
            r_perf_bubble <= r_perf_bubble + 1'b1;
        end else if (!stall_i) begin
            if (flush_i) begin
                r_perf_bubble <= r_perf_bubble + 1'b1;
            end else begin
                r_perf_fetch  <= r_perf_fetch + 1'b1;
            end
        end
    end

    assign perf_fetch_o  = r_perf_fetch;
    assign perf_bubble_o = r_perf_bubble;
`endif

    assign imem_addr_o   = r_pc;
    assign if_id_pc_o    = r_if_id_pc;
    assign if_id_pc4_o   = r_if_id_pc4;
    assign if_id_instr_o = r_if_id_instr;
    assign if_id_valid_o = r_if_id_valid;
    assign misalign_o    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed scenarios followed
//            by randomized stall/flush/redirect/reset traffic vs. a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redir;
    logic [31:0] rpc;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_pc, if_pc4, if_instr;
    logic        if_valid, misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_bubble;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
    logic        m_valid, m_mis;
    int unsigned m_fetch, m_bubble;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0113;
        if (a == 32'h4) return 32'h0070_0193;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = mem_f(imem_addr);

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .if_id_pc_o    (if_pc),
        .if_id_pc4_o   (if_pc4),
        .if_id_instr_o (if_instr),
        .if_id_valid_o (if_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_o  (perf_fetch),
        .perf_bubble_o (perf_bubble),
`endif
        .misalign_o    (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the architectural rules,
    // then compare every observable output.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic d, input logic [31:0] t);
        rst = r; stall = s; flush = f; redir = d; rpc = t;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = C_RESET_PC; m_ifpc = 0; m_ifpc4 = 0; m_instr = C_NOP;
            m_valid = 0; m_mis = 0; m_fetch = 0; m_bubble = 0;
        end else begin
            m_mis = d && (t % 4 != 0);
            if (d) begin
                m_pc = t - (t % 4);
                m_instr = C_NOP; m_valid = 0; m_bubble++;
            end else if (s) begin
                if (f) begin m_instr = C_NOP; m_valid = 0; end
            end else begin
                if (f) begin
                    m_instr = C_NOP; m_valid = 0; m_bubble++;
                end else begin
                    m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
                    m_instr = mem_f(m_pc); m_valid = 1; m_fetch++;
                end
                m_pc = m_pc + 4;
            end
        end
        chk("imem_addr", imem_addr, m_pc);
        chk("if_pc", if_pc, m_ifpc);
        chk("if_pc4", if_pc4, m_ifpc4);
        chk("if_instr", if_instr, m_instr);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, m_fetch);
        chk("perf_bubble", perf_bubble, m_bubble);
`endif
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; redir = 0; rpc = 0;
        m_fetch = 0; m_bubble = 0;
        step(1, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", if_instr, 32'h0000_0013);

        // Free run from reset
        step(0, 0, 0, 0, 0);
        chk("e1_instr", if_instr, 32'h0050_0113);
        step(0, 0, 0, 0, 0);
        chk("e2_instr", if_instr, 32'h0070_0193);
        chk("e2_pc", if_pc, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("pc_0c", imem_addr, 32'hC);

        // Stall three cycles at pc=0x0C
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("stall_addr", imem_addr, 32'hC);
            chk("stall_ifpc", if_pc, 32'h8);
        end

        // Redirect to 0x20, one bubble then target
        step(0, 0, 0, 1, 32'h20);
        chk("redir_addr", imem_addr, 32'h20);
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("redir_tgt_pc", if_pc, 32'h20);
        chk("redir_tgt_valid", {31'd0, if_valid}, 32'd1);

        // Redirect with stall: redirect wins
        step(0, 1, 0, 1, 32'h40);
        chk("rs_addr", imem_addr, 32'h40);

        // Misaligned target
        step(0, 0, 0, 1, 32'h22);
        chk("mis_addr", imem_addr, 32'h20);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        step(0, 0, 0, 0, 0);
        chk("mis_clear", {31'd0, misalign}, 32'd0);

        // Stall+flush, then plain flush
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // PC wrap at top of address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Mid-run reset with competing inputs
        step(1, 1, 0, 1, 32'h1234_5677);
        chk("mrst_addr", imem_addr, C_RESET_PC);

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h100);
        chk("perf4_fetch", perf_fetch, 32'd4);
        chk("perf1_bubble", perf_bubble, 32'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, d;
            logic [31:0] t;
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       t = $urandom;
                1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: t = $urandom & 32'h0000_03FF;
            endcase
            step(r, s, f, d, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
